// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush sequencer for the 5-stage CPU.
// Detects RAW hazards against EX and MEM that the ID-stage WB bypass cannot
// cover, turns a taken ID branch into an IF_ID flush, and runs the interrupt
// entry/return FSM that tags the instruction entering ID.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds the stall_cnt port,
// a saturating count of hazard-stall cycles.
module pipe_hazard_ctrl #(
  parameter int NUM_REGS    = 16,
  parameter int STALL_CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd1,
  input  logic [$clog2(NUM_REGS)-1:0] id_rd2,
  input  logic                        id_rd1_used,
  input  logic                        id_rd2_used,
  input  logic                        id_branch_sel,
  input  logic                        ex_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] ex_reg_dst,
  input  logic                        mem_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] mem_reg_dst,
  input  logic                        ex_returni,
  input  logic                        irq,
  output logic                        stall_if,
  output logic                        stall_id,
  output logic                        bubble_ex,
  output logic                        flush_if_id,
  output logic                        int_inject,
  output logic                        int_ack,
  output logic                        in_isr
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    ISR   = 2'd2
  } state_t;

  state_t state;
  logic   enter_flag;
  logic   haz;

  // A zero-width counter makes no sense; the generate block only exists to
  // keep the width parameter meaningful in builds without the counter.
  if (STALL_CNT_W < 1) begin : g_bad_cnt_w
  end

  // RAW hazard: a pending EX or MEM write to a register the ID instruction
  // reads. WB writes are covered by the ID bypass, so they are not checked.
  always_comb begin
    haz = (id_rd1_used && ex_reg_wr  && (id_rd1 == ex_reg_dst))  ||
          (id_rd2_used && ex_reg_wr  && (id_rd2 == ex_reg_dst))  ||
          (id_rd1_used && mem_reg_wr && (id_rd1 == mem_reg_dst)) ||
          (id_rd2_used && mem_reg_wr && (id_rd2 == mem_reg_dst));
  end

  // Interrupt FSM with registered entry and in-ISR flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      enter_flag <= 1'b0;
      in_isr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Entry waits for a cycle with neither a stall nor a flush, so
          // the tagged instruction is the one actually entering ID.
          if (irq && !haz && !id_branch_sel) begin
            state      <= ENTER;
            enter_flag <= 1'b1;
          end
        end
        ENTER: begin
          state      <= ISR;
          enter_flag <= 1'b0;
          in_isr     <= 1'b1;
        end
        ISR: begin
          if (ex_returni) begin
            state  <= IDLE;
            in_isr <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          enter_flag <= 1'b0;
          in_isr     <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline controls: reset forces a NOP into IF_ID and ID_EX, then
  // hazard stall beats branch flush; entry only adds a PC hold and tags.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    int_inject  = 1'b0;
    int_ack     = 1'b0;
    if (!rst_n) begin
      bubble_ex   = 1'b1;
      flush_if_id = 1'b1;
    end else begin
      if (haz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (id_branch_sel) begin
        flush_if_id = 1'b1;
      end
      if (enter_flag) begin
        int_inject = 1'b1;
        int_ack    = 1'b1;
        stall_if   = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating count of hazard-stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (haz && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table for the combinational hazard and
// branch logic, plus hand-written sequences for the interrupt FSM and reset.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rd1, id_rd2, ex_reg_dst, mem_reg_dst;
  logic       id_rd1_used, id_rd2_used, id_branch_sel;
  logic       ex_reg_wr, mem_reg_wr, ex_returni, irq;
  logic       stall_if, stall_id, bubble_ex, flush_if_id;
  logic       int_inject, int_ack, in_isr;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_REGS(16), .STALL_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_rd1_used(id_rd1_used), .id_rd2_used(id_rd2_used),
    .id_branch_sel(id_branch_sel),
    .ex_reg_wr(ex_reg_wr), .ex_reg_dst(ex_reg_dst),
    .mem_reg_wr(mem_reg_wr), .mem_reg_dst(mem_reg_dst),
    .ex_returni(ex_returni), .irq(irq),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .int_inject(int_inject), .int_ack(int_ack),
    .in_isr(in_isr)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] rd1, rd2;
    logic       u1, u2, br, exw;
    logic [3:0] exd;
    logic       mw;
    logic [3:0] md;
    logic [3:0] exp;  // {stall_if, stall_id, bubble_ex, flush_if_id}
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string name, logic [3:0] rd1, logic [3:0] rd2,
                              logic u1, logic u2, logic br, logic exw,
                              logic [3:0] exd, logic mw, logic [3:0] md,
                              logic [3:0] exp);
    vec_t v;
    v.name = name; v.rd1 = rd1; v.rd2 = rd2; v.u1 = u1; v.u2 = u2;
    v.br = br; v.exw = exw; v.exd = exd; v.mw = mw; v.md = md; v.exp = exp;
    return v;
  endfunction

  // {stall_if, stall_id, bubble_ex, flush_if_id, int_inject, int_ack}
  function automatic logic [5:0] ctl();
    return {stall_if, stall_id, bubble_ex, flush_if_id, int_inject, int_ack};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_rd1 = 0; id_rd2 = 0; id_rd1_used = 0; id_rd2_used = 0;
    id_branch_sel = 0; ex_reg_wr = 0; ex_reg_dst = 0;
    mem_reg_wr = 0; mem_reg_dst = 0; ex_returni = 0; irq = 0;
  endtask

  // Places a producer of r5 in EX with an ID consumer of r5 on rd1.
  task automatic ex_haz5();
    id_rd1 = 4'd5; id_rd1_used = 1; ex_reg_wr = 1; ex_reg_dst = 4'd5;
  endtask

  initial begin
    vecs[0]  = mk("ex_rd1",        5, 0, 1, 0, 0, 1, 5, 0, 0, 4'b1110);
    vecs[1]  = mk("ex_rd1_unused", 5, 0, 0, 0, 0, 1, 5, 0, 0, 4'b0000);
    vecs[2]  = mk("mem_rd1",       5, 0, 1, 0, 0, 0, 0, 1, 5, 4'b1110);
    vecs[3]  = mk("ex_rd2",        0, 7, 0, 1, 0, 1, 7, 0, 0, 4'b1110);
    vecs[4]  = mk("mem_no_wr",     0, 7, 0, 1, 0, 0, 0, 0, 7, 4'b0000);
    vecs[5]  = mk("reg0_haz",      0, 9, 1, 0, 0, 1, 0, 0, 0, 4'b1110);
    vecs[6]  = mk("dst_differs",   3, 6, 1, 1, 0, 1, 4, 1, 2, 4'b0000);
    vecs[7]  = mk("branch",        1, 2, 1, 1, 1, 0, 1, 0, 2, 4'b0001);
    vecs[8]  = mk("branch_haz",    1, 2, 1, 1, 1, 0, 0, 1, 2, 4'b1110);
    vecs[9]  = mk("branch_unused", 8, 0, 0, 0, 1, 1, 8, 0, 0, 4'b0001);
    vecs[10] = mk("both_stages",   4, 6, 1, 1, 0, 1, 6, 1, 4, 4'b1110);
    vecs[11] = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

    clr_inputs();
    rst_n = 0;

    // Reset: NOP forced into IF_ID and ID_EX while rst_n is low.
    @(negedge clk);
    chk("reset_ctl", 32'(ctl()), 32'(6'b001100));
    tick();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("reset_in_isr", 32'(in_isr), 0);
    chk("post_reset_ctl", 32'(ctl()), 0);

    // Combinational hazard/branch table.
    for (int i = 0; i < 12; i++) begin
      tick();
      id_rd1 = vecs[i].rd1; id_rd2 = vecs[i].rd2;
      id_rd1_used = vecs[i].u1; id_rd2_used = vecs[i].u2;
      id_branch_sel = vecs[i].br;
      ex_reg_wr = vecs[i].exw; ex_reg_dst = vecs[i].exd;
      mem_reg_wr = vecs[i].mw; mem_reg_dst = vecs[i].md;
      @(negedge clk);
      chk(vecs[i].name, 32'(ctl()), 32'({vecs[i].exp, 2'b00}));
    end

    // Producer walks EX -> MEM -> WB: two stall cycles, then clear.
    tick(); clr_inputs(); ex_haz5();
    @(negedge clk); chk("seq_ex_stall", 32'(ctl()), 32'(6'b111000));
    tick(); ex_reg_wr = 0; mem_reg_wr = 1; mem_reg_dst = 4'd5;
    @(negedge clk); chk("seq_mem_stall", 32'(ctl()), 32'(6'b111000));
    tick(); mem_reg_wr = 0;
    @(negedge clk); chk("seq_wb_clear", 32'(ctl()), 0);

    // Branch held under a stall flushes only once the stall drops.
    tick(); ex_haz5(); id_branch_sel = 1;
    @(negedge clk); chk("br_under_stall", 32'(flush_if_id), 0);
    tick(); ex_reg_wr = 0;
    @(negedge clk); chk("br_after_stall", 32'(flush_if_id), 1);

    // Interrupt entry, ignored irq in ISR, and returni.
    tick(); clr_inputs(); irq = 1;
    @(negedge clk); chk("irq_idle_no_ack", 32'(int_ack), 0);
    tick(); irq = 0;
    @(negedge clk);
    chk("enter_ctl", 32'({stall_if, int_inject, int_ack}), 32'(3'b111));
    chk("enter_not_isr", 32'(in_isr), 0);
    tick();
    @(negedge clk);
    chk("isr_flag", 32'(in_isr), 1);
    chk("isr_ack_pulse", 32'({int_inject, int_ack}), 0);
    irq = 1;
    tick(); irq = 0;
    @(negedge clk);
    chk("isr_irq_ignored", 32'({int_ack, in_isr}), 32'(2'b01));
    ex_returni = 1;
    tick(); ex_returni = 0;
    @(negedge clk); chk("returni_exit", 32'(in_isr), 0);

    // Deferred irq: held through a 2-cycle hazard, acked afterwards.
    tick(); clr_inputs(); irq = 1; ex_haz5();
    @(negedge clk); chk("defer_c0", 32'(int_ack), 0);
    tick(); ex_reg_wr = 0; mem_reg_wr = 1; mem_reg_dst = 4'd5;
    @(negedge clk); chk("defer_c1", 32'(int_ack), 0);
    tick(); mem_reg_wr = 0;
    @(negedge clk); chk("defer_c2", 32'(int_ack), 0);
    tick(); irq = 0;
    @(negedge clk); chk("defer_ack", 32'(int_ack), 1);
    tick();
    @(negedge clk); chk("defer_ack_once", 32'({int_ack, in_isr}), 32'(2'b01));

    // Reset mid-ISR.
    tick(); rst_n = 0;
    @(negedge clk); chk("rst_isr_ctl", 32'(ctl()), 32'(6'b001100));
    tick(); rst_n = 1;
    @(negedge clk);
    chk("rst_isr_exit", 32'(in_isr), 0);
    chk("rst_isr_no_ack", 32'(int_ack), 0);

    // Reset during ENTER returns to IDLE without an ack.
    tick(); irq = 1;
    tick(); irq = 0; rst_n = 0;
    @(negedge clk); chk("rst_enter_ctl", 32'(ctl()), 32'(6'b001100));
    tick(); rst_n = 1;
    @(negedge clk);
    chk("rst_enter_idle", 32'({int_ack, in_isr}), 0);
    tick();
    @(negedge clk); chk("rst_enter_stays_idle", 32'({int_ack, in_isr}), 0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("cnt_after_reset", stall_cnt, 0);
    ex_haz5();
    tick(); tick(); tick();
    clr_inputs();
    @(negedge clk); chk("cnt_three", stall_cnt, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
